// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared message format, field indices and row FSM state for pe_array_feeder
// No ports. Message layout is {is_flush, is_weight, data}. The packed typedef and the
// index constants describe the default 8-bit build; modules derive their own widths
// from msg_width().
package pe_array_pkg;
  localparam int DEF_BIT_WIDTH = 8;
  function automatic int msg_width(input int bit_width);
    return bit_width + 2;
  endfunction
  localparam int FLUSH_BIT = msg_width(DEF_BIT_WIDTH) - 1;
  localparam int WEIGHT_BIT = msg_width(DEF_BIT_WIDTH) - 2;
  typedef struct packed {
    logic is_flush;
    logic is_weight;
    logic [DEF_BIT_WIDTH-1:0] data;
  } pe_msg_t;
  typedef enum logic {SEND, FLUSH} row_state_t;
endpackage

// File: rtl/pe_array_feeder_row.sv
// pe_array_feeder_row: one row FIFO plus SEND/FLUSH message FSM for a single PE row
// Ports: i_clk, i_rst (sync, active-high); push/push_data/push_weight/push_last write one
// entry; full reports a full FIFO; msg/val/rdy form the row's outgoing message port.
module pe_array_feeder_row import pe_array_pkg::*; #(
  parameter int BIT_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int MSG_WIDTH = msg_width(BIT_WIDTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 push,
  input  logic [BIT_WIDTH-1:0] push_data,
  input  logic                 push_weight,
  input  logic                 push_last,
  output logic                 full,
  output logic [MSG_WIDTH-1:0] msg,
  output logic                 val,
  input  logic                 rdy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [MSG_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [MSG_WIDTH-1:0] head;
  logic pop, flush_done;
  row_state_t state;
  // Storage keeps the "ends block" marker in the top bit; it never reaches the output.
  assign head = mem[rp];
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign val = state == FLUSH || cnt != '0;
  assign msg = state == FLUSH ? {1'b1, {(MSG_WIDTH-1){1'b0}}}
             : cnt != '0 ? {1'b0, head[MSG_WIDTH-2:0]} : '0;
  assign pop = state == SEND && cnt != '0 && rdy;
  assign flush_done = state == FLUSH && rdy;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      state <= SEND;
    end else begin
      if (push) begin
        mem[wp] <= {push_last && !push_weight, push_weight, push_data};
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      state <= pop && head[MSG_WIDTH-1] ? FLUSH : flush_done ? SEND : state;
    end
  end
endmodule

// File: rtl/pe_array_feeder.sv
// pe_array_feeder: fans row-vectors out into per-row FIFOs and drives each PE row's val/rdy port
// Ports: i_clk, i_rst (sync, active-high); i_vec_recv_* is the shared vector input with
// o_vec_recv_rdy; o_msg_send_msg/o_msg_send_val/i_msg_send_rdy are the per-row message ports.
// Optional PE_ARRAY_FEEDER_STATS_EN adds saturating o_stat_vec_count and o_stat_flush_count.
module pe_array_feeder import pe_array_pkg::*; #(
  parameter int NUM_ROWS = 2,
  parameter int BIT_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int MSG_WIDTH = msg_width(BIT_WIDTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [BIT_WIDTH-1:0] i_vec_recv_data [NUM_ROWS],
  input  logic                 i_vec_recv_is_weight,
  input  logic                 i_vec_recv_last,
  input  logic                 i_vec_recv_val,
  output logic                 o_vec_recv_rdy,
  output logic [MSG_WIDTH-1:0] o_msg_send_msg [NUM_ROWS],
  output logic [NUM_ROWS-1:0]  o_msg_send_val,
  input  logic [NUM_ROWS-1:0]  i_msg_send_rdy
`ifdef PE_ARRAY_FEEDER_STATS_EN
  ,
  output logic [31:0]          o_stat_vec_count,
  output logic [31:0]          o_stat_flush_count
`endif
);
  logic [NUM_ROWS-1:0] full;
  logic push;
  // A vector is accepted only when every row can take its element, so rows never split a vector.
  assign o_vec_recv_rdy = !i_rst && full == '0;
  assign push = i_vec_recv_val && o_vec_recv_rdy;
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    pe_array_feeder_row #(.BIT_WIDTH(BIT_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_row (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .push(push),
      .push_data(i_vec_recv_data[r]),
      .push_weight(i_vec_recv_is_weight),
      .push_last(i_vec_recv_last),
      .full(full[r]),
      .msg(o_msg_send_msg[r]),
      .val(o_msg_send_val[r]),
      .rdy(i_msg_send_rdy[r])
    );
  end
`ifdef PE_ARRAY_FEEDER_STATS_EN
  logic [32:0] flush_sum;
  always_comb begin
    flush_sum = {1'b0, o_stat_flush_count};
    for (int i = 0; i < NUM_ROWS; i++)
      flush_sum = flush_sum + 33'(o_msg_send_val[i] && i_msg_send_rdy[i] && o_msg_send_msg[i][MSG_WIDTH-1]);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stat_vec_count <= '0;
      o_stat_flush_count <= '0;
    end else begin
      if (push && o_stat_vec_count != '1) o_stat_vec_count <= o_stat_vec_count + 32'd1;
      o_stat_flush_count <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end
`endif
endmodule

// File: doc/pe_array_feeder.md
Name: pe_array_feeder

Overview:
- Stage directly upstream of processing_element_array.
- Accepts whole row-vectors (one element per PE row) from the matrix loader and fans them out into per-row FIFOs.
- Drives each array row's independent val/rdy message port, encoding is_weight/is_flush bits.
- Inserts one flush message per row after the last activation vector of a block, so array rows drain and stall independently.

Parameters:
- NUM_ROWS, 2, number of PE rows (array message ports).
- BIT_WIDTH, 8, data element width.
- FIFO_DEPTH, 4, entries per row FIFO; power of two, >=2.
- MSG_WIDTH, BIT_WIDTH+2, derived, not overridable: [MSG_WIDTH-1]=is_flush, [MSG_WIDTH-2]=is_weight, [BIT_WIDTH-1:0]=data.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_vec_recv_data  in  [BIT_WIDTH-1:0] x NUM_ROWS (unpacked)  one element per row.
- i_vec_recv_is_weight  in  1  vector is a weight column.
- i_vec_recv_last  in  1  last activation vector of block; ignored when is_weight=1.
- i_vec_recv_val  in  1  input valid.
- o_vec_recv_rdy  out  1  input ready.
- o_msg_send_msg  out  [MSG_WIDTH-1:0] x NUM_ROWS (unpacked)  to array i_msg_recv_msg.
- o_msg_send_val  out  [NUM_ROWS-1:0]  per-row valid.
- i_msg_send_rdy  in  [NUM_ROWS-1:0]  per-row ready from array.

Behaviour:
- Reset (synchronous, active-high): all FIFOs empty, row FSMs in SEND, o_vec_recv_rdy=0 during reset, o_msg_send_val=0, o_msg_send_msg=0.
- Input handshake:
  - o_vec_recv_rdy = every row FIFO not full (combinational from registered counts).
  - Transfer when val&&rdy: one entry {last&&!is_weight, is_weight, data[r]} pushed into every row FIFO in the same cycle.
  - Vectors are never split across rows.
- Row FIFO:
  - Registered storage, wrap-around pointers, count 0..FIFO_DEPTH.
  - Simultaneous push and pop when full: legal, count unchanged; rdy still reports full that cycle (no bypass).
  - Push into an empty FIFO is visible at the output the next cycle (1-cycle min latency input->o_msg_send_val).
- Row FSM (one per row), states SEND and FLUSH:
  - SEND:
    - o_msg_send_val[r] = FIFO not empty; msg = {0, is_weight, data} of head entry.
    - On val&&rdy: pop. If the popped entry had last=1, go to FLUSH; else stay in SEND.
  - FLUSH:
    - o_msg_send_val[r]=1; msg = {1, 0, zero data}. No pop.
    - On rdy: return to SEND.
    - New head entries wait behind the flush; pushes still accepted.
- val must not drop and msg must not change while rdy=0 (stable-until-accepted).
- Rows are independent: row 0 may be several entries ahead of row 1; the shared input stalls only on a full FIFO.
- Weight vectors never generate flushes even if last=1.
- Reset mid-operation: FIFOs and FSMs are cleared next edge; pending flushes are discarded; no partial message is held.
- No arithmetic on data; width preserved exactly.

Optional Feature:
- Macro: PE_ARRAY_FEEDER_STATS_EN.
- Defined:
  - Adds o_stat_vec_count (32b, +1 per accepted input vector) and o_stat_flush_count (32b, +1 per accepted flush message, summed over rows; multiple rows in the same cycle add their count).
  - Both counters reset to 0 and saturate at all-ones.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package pe_array_pkg: MSG_WIDTH derivation function; field index constants FLUSH_BIT and WEIGHT_BIT; packed typedef for {is_flush, is_weight, data}; row FSM state enum.
- Sub-module pe_array_feeder_row: one row FIFO plus SEND/FLUSH FSM, instantiated NUM_ROWS times via generate.

Test Plan:
- Weights: 2 weight vectors {1,0},{0,1} with rows always ready -> each row emits 2 msgs with is_weight=1 and data in order (row0: 1,0; row1: 0,1); no flush; val low after.
- Activation block: vectors {1,3},{2,4}(last) -> row0 emits 1,2,flush(0x200); row1 emits 3,4,flush; is_weight=0 on all.
- Backpressure: row1 rdy=0 while 4 activation vectors are pushed -> o_vec_recv_rdy=0 after the 4th push (DEPTH=4) and row0 drains fully; raising row1 rdy releases all 4 in order, then o_vec_recv_rdy=1.
- Flush stall: last vector pushed, then 1 more vector queued, with row0 rdy=0 during FLUSH -> flush msg held stable; next data appears only after the flush is accepted.
- Reset mid-stream: assert i_rst with 3 entries queued and a row in FLUSH -> next cycle all val=0 and rdy=0; after deassert, a fresh vector {5,6} emerges first with no stale flush.
- With PE_ARRAY_FEEDER_STATS_EN: the above activation block -> o_stat_vec_count=2, o_stat_flush_count=2.
